// File: rtl/dac_spi_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dac_pkg : shared frame constants, FSM states, frame builder         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package dac_pkg;

  localparam int FRAME_W    = 16;
  localparam int CTRL_W     = 4;
  localparam int DAC_DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [CTRL_W-1:0]     ctrl,
    input logic [DAC_DATA_W-1:0] sample,
    input int                    pad
  );
    return {ctrl, sample << pad};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_spi_tx_sample_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sample_fifo : synchronous first-word-fall-through sample FIFO       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sample_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dac_spi_tx : buffered, paced 16-bit SPI frame serializer for a DAC  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int                DATA_W     = 12,
  parameter logic [CTRL_W-1:0] CTRL_BITS  = 4'b0000,
  parameter int                SCLK_DIV   = 2,
  parameter int                SYNC_HIGH  = 2,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              dac_sync,
  output logic              dac_sclk,
  output logic              dac_sdi,
  output logic              frame_done,
  output logic              underrun
);

  localparam int PH_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int HC_W = (SYNC_HIGH > 1) ? $clog2(SYNC_HIGH) : 1;
  localparam logic [PH_W-1:0] c_PH_LAST   = PH_W'(SCLK_DIV - 1);
  localparam logic [HC_W-1:0] c_HOLD_LAST = HC_W'(SYNC_HIGH - 1);

  state_t               r_state, w_state_nxt;
  logic [PH_W-1:0]      r_phase, w_phase_nxt;
  logic [3:0]           r_bit, w_bit_nxt;
  logic [HC_W-1:0]      r_hold, w_hold_nxt;
  logic [FRAME_W-2:0]   r_shreg, w_shreg_nxt;
  logic                 r_sync, w_sync_nxt;
  logic                 r_sclk, w_sclk_nxt;
  logic                 r_sdi, w_sdi_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_und, w_und_nxt;
  logic                 r_avail;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_W-1:0]    w_rdata;
  logic [FRAME_W-1:0]   w_frame;

  assign s_ready = !rst && !w_full;
  assign w_push  = s_valid && s_ready;
  assign w_frame = build_frame(CTRL_BITS, DAC_DATA_W'(w_rdata), DAC_DATA_W - DATA_W);

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (s_data),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_hold_nxt  = r_hold;
    w_shreg_nxt = r_shreg;
    w_sync_nxt  = r_sync;
    w_sclk_nxt  = r_sclk;
    w_sdi_nxt   = r_sdi;
    w_done_nxt  = 1'b0;
    w_und_nxt   = 1'b0;
    w_pop       = 1'b0;

    case (r_state)
      IDLE: begin
        w_sync_nxt = 1'b1;
        w_sclk_nxt = 1'b0;
        // Launch waits on a registered occupancy view, giving a freshly
        // written sample one settling cycle before it is framed.
        if (en && r_avail && !w_empty) begin
          w_pop       = 1'b1;
          w_shreg_nxt = w_frame[FRAME_W-2:0];
          w_sdi_nxt   = w_frame[FRAME_W-1];
          w_sync_nxt  = 1'b0;
          w_phase_nxt = '0;
          w_bit_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        if (r_phase == c_PH_LAST) begin
          w_phase_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else if (r_bit == 4'd15) begin
            w_state_nxt = HOLD;
            w_sync_nxt  = 1'b1;
            w_sclk_nxt  = 1'b0;
            w_sdi_nxt   = 1'b0;
            w_hold_nxt  = '0;
            w_done_nxt  = 1'b1;
            w_und_nxt   = w_empty && en;
          end else begin
            w_bit_nxt   = r_bit + 4'd1;
            w_sclk_nxt  = 1'b0;
            w_sdi_nxt   = r_shreg[FRAME_W-2];
            w_shreg_nxt = {r_shreg[FRAME_W-3:0], 1'b0};
          end
        end else begin
          w_phase_nxt = r_phase + PH_W'(1);
        end
      end

      HOLD: begin
        if (r_hold == c_HOLD_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_hold_nxt = r_hold + HC_W'(1);
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_hold  <= '0;
      r_shreg <= '0;
      r_sync  <= 1'b1;
      r_sclk  <= 1'b0;
      r_sdi   <= 1'b0;
      r_done  <= 1'b0;
      r_und   <= 1'b0;
      r_avail <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;
      r_hold  <= w_hold_nxt;
      r_shreg <= w_shreg_nxt;
      r_sync  <= w_sync_nxt;
      r_sclk  <= w_sclk_nxt;
      r_sdi   <= w_sdi_nxt;
      r_done  <= w_done_nxt;
      r_und   <= w_und_nxt;
      r_avail <= !w_empty;
    end
  end

  assign dac_sync   = r_sync;
  assign dac_sclk   = r_sclk;
  assign dac_sdi    = r_sdi;
  assign frame_done = r_done;
  assign underrun   = r_und;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dac_spi_tx : two-configuration bench with frame-timeline model   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        s_valid0, s_valid1;
  logic [11:0] s_data0;
  logic [7:0]  s_data1;
  logic        s_ready0, s_ready1;
  logic        sync0, sync1, sclk0, sclk1, sdi0, sdi1;
  logic        fd0, fd1, und0, und1;

  always #5 clk = ~clk;

  dac_spi_tx u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .s_valid    (s_valid0),
    .s_ready    (s_ready0),
    .s_data     (s_data0),
    .dac_sync   (sync0),
    .dac_sclk   (sclk0),
    .dac_sdi    (sdi0),
    .frame_done (fd0),
    .underrun   (und0)
  );

  dac_spi_tx #(
    .DATA_W     (8),
    .CTRL_BITS  (4'b0011),
    .SCLK_DIV   (1),
    .SYNC_HIGH  (1),
    .FIFO_DEPTH (4)
  ) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .s_valid    (s_valid1),
    .s_ready    (s_ready1),
    .s_data     (s_data1),
    .dac_sync   (sync1),
    .dac_sclk   (sclk1),
    .dac_sdi    (sdi1),
    .frame_done (fd1),
    .underrun   (und1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame capture on SCLK rising edges, latched when frame_done pulses.
  logic [15:0] cap0 = '0, cap1 = '0, last0 = '0, last1 = '0;
  logic        p_sclk0 = 1'b0, p_sclk1 = 1'b0;
  always @(negedge clk) begin
    p_sclk0 <= sclk0;
    p_sclk1 <= sclk1;
    if (sclk0 && !p_sclk0) cap0 <= {cap0[14:0], sdi0};
    if (sclk1 && !p_sclk1) cap1 <= {cap1[14:0], sdi1};
    if (fd0) last0 <= cap0;
    if (fd1) last1 <= cap1;
  end

  // Reference model: a FIFO of frame words plus the position (in cycles)
  // within the current frame; -1 means idle.
  logic [15:0] m_q [2][4];
  int          m_cnt [2];
  int          m_rd  [2];
  int          m_pos [2];
  bit          m_avail [2];
  bit          m_und [2];
  logic [15:0] m_word [2];

  function automatic int f_div(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int f_sh(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int          div;
      int          sh;
      bit          v;
      bit          pre_empty;
      bit          push;
      logic [15:0] w;
      div = f_div(d);
      sh  = f_sh(d);
      v   = (d == 0) ? s_valid0 : s_valid1;
      w   = (d == 0) ? {4'h0, s_data0} : {4'b0011, s_data1, 4'h0};
      if (rst) begin
        m_cnt[d]   = 0;
        m_rd[d]    = 0;
        m_pos[d]   = -1;
        m_avail[d] = 1'b0;
        m_und[d]   = 1'b0;
      end else begin
        pre_empty = (m_cnt[d] == 0);
        push      = v && (m_cnt[d] < 4);
        m_und[d]  = 1'b0;
        if (m_pos[d] >= 0) begin
          m_pos[d]++;
          if (m_pos[d] == 32 * div) m_und[d] = pre_empty && en;
          if (m_pos[d] == 32 * div + sh) m_pos[d] = -1;
        end else if (en && m_avail[d]) begin
          m_word[d] = m_q[d][m_rd[d]];
          m_rd[d]   = (m_rd[d] + 1) % 4;
          m_cnt[d]--;
          m_pos[d]  = 0;
        end
        if (push) begin
          m_q[d][(m_rd[d] + m_cnt[d]) % 4] = w;
          m_cnt[d]++;
        end
        m_avail[d] = !pre_empty;
      end
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      int div;
      int pos;
      bit in_shift;
      bit e_sdi;
      div      = f_div(d);
      pos      = m_pos[d];
      in_shift = (pos >= 0) && (pos < 32 * div);
      e_sdi    = in_shift ? m_word[d][15 - pos / (2 * div)] : 1'b0;
      chk($sformatf("d%0d sync", d),  (d == 0) ? sync0 : sync1, !in_shift);
      chk($sformatf("d%0d sclk", d),  (d == 0) ? sclk0 : sclk1,
          in_shift && ((pos % (2 * div)) >= div));
      chk($sformatf("d%0d sdi", d),   (d == 0) ? sdi0 : sdi1, e_sdi);
      chk($sformatf("d%0d frame_done", d), (d == 0) ? fd0 : fd1, pos == 32 * div);
      chk($sformatf("d%0d underrun", d), (d == 0) ? und0 : und1, m_und[d]);
      chk($sformatf("d%0d s_ready", d), (d == 0) ? s_ready0 : s_ready1,
          !rst && (m_cnt[d] < 4));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    int acc0;
    int acc1;
    int guard;
    bit r0;
    bit r1;

    rst = 1'b1; en = 1'b0;
    s_valid0 = 1'b0; s_valid1 = 1'b0; s_data0 = '0; s_data1 = '0;
    repeat (3) tick();
    rst = 1'b0; en = 1'b1;

    // Single sample on each configuration.
    s_valid0 = 1'b1; s_data0 = 12'hA5C;
    s_valid1 = 1'b1; s_data1 = 8'hFF;
    tick();
    s_valid0 = 1'b0; s_valid1 = 1'b0;
    repeat (80) tick();
    chk("d0 captured word", last0, 16'h0A5C);
    chk("d1 captured word", last1, 16'h3FF0);

    // Burst of six samples with valid held high.
    acc0 = 0; acc1 = 0; guard = 0;
    while ((acc0 < 6 || acc1 < 6) && guard < 2000) begin
      s_valid0 = (acc0 < 6); s_data0 = 12'(acc0 + 1);
      s_valid1 = (acc1 < 6); s_data1 = 8'($urandom);
      r0 = s_ready0; r1 = s_ready1;
      tick();
      if (r0 && s_valid0) acc0++;
      if (r1 && s_valid1) acc1++;
      guard++;
    end
    s_valid0 = 1'b0; s_valid1 = 1'b0;
    chk("d0 burst accepted", acc0, 6);
    chk("d1 burst accepted", acc1, 6);
    repeat (450) tick();
    chk("d0 last burst word", last0, 16'h0006);

    // en low with two samples queued, then a short enable window.
    en = 1'b0;
    repeat (2) begin
      s_valid0 = 1'b1; s_data0 = 12'($urandom);
      s_valid1 = 1'b1; s_data1 = 8'($urandom);
      tick();
    end
    s_valid0 = 1'b0; s_valid1 = 1'b0;
    repeat (20) tick();
    en = 1'b1;
    repeat (4) tick();
    en = 1'b0;
    repeat (150) tick();
    en = 1'b1;
    repeat (150) tick();

    // Reset around bit 7 of a frame.
    s_valid0 = 1'b1; s_data0 = 12'($urandom);
    s_valid1 = 1'b1; s_data1 = 8'($urandom);
    tick();
    s_valid0 = 1'b0; s_valid1 = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (100) tick();

    // Randomised traffic with occasional en drops and resets.
    repeat (3000) begin
      en       = ($urandom_range(0, 9) != 0);
      rst      = ($urandom_range(0, 599) == 0);
      s_valid0 = ($urandom_range(0, 99) < 4);
      s_valid1 = ($urandom_range(0, 99) < 8);
      s_data0  = 12'($urandom);
      s_data1  = 8'($urandom);
      tick();
    end
    rst = 1'b0; en = 1'b1; s_valid0 = 1'b0; s_valid1 = 1'b0;
    repeat (400) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
